// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg
// Shared encodings for the memory responder: access size, operation and
// FSM state, plus small helpers for lane alignment and misalignment checks.
// No ports (package).
package memory_responder_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'd0,
        MEM_HALF    = 2'd1,
        MEM_WORD    = 2'd2,
        MEM_INVALID = 2'd3
    } mem_size_e;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_e;

    // Aligns a byte lane down to the natural boundary of the access size.
    function automatic logic [1:0] align_lane(mem_size_e size, logic [1:0] lane);
        logic [1:0] aligned;
        case (size)
            MEM_BYTE: aligned = lane;
            MEM_HALF: aligned = {lane[1], 1'b0};
            default:  aligned = 2'b00;
        endcase
        return aligned;
    endfunction

    // True when the request cannot be serviced as issued.
    function automatic logic misaligned(mem_size_e size, logic [1:0] lane);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = lane[0];
            MEM_WORD: bad = (lane != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_lane_align.sv
// memory_lane_align
// Combinational little-endian lane handling for the memory responder.
// Ports:
//   size       access size (byte/half/word; anything else behaves as word)
//   lane       byte lane within the word (already aligned by the caller)
//   word       current contents of the addressed word
//   store_data right-justified store data
//   load_data  addressed lane(s) right-justified and zero-extended
//   merged     word with only the addressed lane(s) replaced by store_data
module memory_lane_align
    import memory_responder_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  mem_size_e         size,
    input  logic [1:0]        lane,
    input  logic [SIZE-1:0]   word,
    input  logic [SIZE-1:0]   store_data,
    output logic [SIZE-1:0]   load_data,
    output logic [SIZE-1:0]   merged
);

    logic [4:0]      shift;
    logic [SIZE-1:0] shifted;
    logic [SIZE-1:0] mask;

    assign shift = {lane, 3'b000};

    always_comb begin
        shifted   = word >> shift;
        load_data = word;
        mask      = '1;
        case (size)
            MEM_BYTE: begin
                load_data = SIZE'(shifted[7:0]);
                mask      = SIZE'(8'hFF) << shift;
            end
            MEM_HALF: begin
                load_data = SIZE'(shifted[15:0]);
                mask      = SIZE'(16'hFFFF) << shift;
            end
            default: begin
                load_data = word;
                mask      = '1;
            end
        endcase
        merged = (word & ~mask) | ((store_data << shift) & mask);
    end

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Word-addressed data memory answering one load/store request at a time
// after LATENCY cycles, with a one-cycle memory_ready pulse. Byte/half
// stores are read-modify-write merges into the addressed word.
// Optional feature macro: MEMORY_RESPONDER_ERROR_EN -- when defined,
// misaligned or size-3 requests are rejected with memory_error; otherwise
// they are aligned down (size 3 treated as word) and memory_error stays 0.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   memory_enable       request valid (level)
//   memory_operation    0 = load, 1 = store
//   memory_data_size    0 = byte, 1 = half, 2 = word, 3 = invalid
//   memory_address      byte address (upper bits wrap)
//   memory_data_out     store data, right-justified
//   memory_ready        one-cycle completion pulse
//   memory_data_in      registered load data, held until the next load
//   memory_error        one-cycle pulse with memory_ready on rejection
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned SIZE        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memory_enable,
    input  logic              memory_operation,
    input  logic [1:0]        memory_data_size,
    input  logic [SIZE-1:0]   memory_address,
    input  logic [SIZE-1:0]   memory_data_out,
    output logic              memory_ready,
    output logic [SIZE-1:0]   memory_data_in,
    output logic              memory_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state;
    logic [CNT_W-1:0]   count;
    mem_op_e            op_q;
    mem_size_e          size_q;
    logic [SIZE-1:0]    addr_q;
    logic [SIZE-1:0]    wdata_q;

    logic [SIZE-1:0]    mem [DEPTH_WORDS];

    mem_op_e            req_op;
    mem_size_e          req_size;
    mem_size_e          eff_size;
    logic [SIZE-1:0]    req_addr;
    logic [SIZE-1:0]    req_wdata;
    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         eff_lane;
    logic               req_err;
    logic [SIZE-1:0]    load_data;
    logic [SIZE-1:0]    merged;
    logic               fire;
    logic               commit;
    logic               unused_addr_bits;

    // Outputs are registered yet must be valid in the ready cycle itself, so
    // they are loaded one edge early. With LATENCY==1 that edge is the
    // acceptance edge, hence the request is taken straight from the inputs
    // while IDLE and from the latched copy otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            req_op    = mem_op_e'(memory_operation);
            req_size  = mem_size_e'(memory_data_size);
            req_addr  = memory_address;
            req_wdata = memory_data_out;
        end else begin
            req_op    = op_q;
            req_size  = size_q;
            req_addr  = addr_q;
            req_wdata = wdata_q;
        end
    end

    assign req_idx          = req_addr[IDX_W+1:2];
    assign unused_addr_bits = ^req_addr[SIZE-1:IDX_W+2];

`ifdef MEMORY_RESPONDER_ERROR_EN
    assign req_err  = misaligned(req_size, req_addr[1:0]);
    assign eff_size = req_size;
    assign eff_lane = req_addr[1:0];
`else
    assign req_err  = 1'b0;
    assign eff_size = (req_size == MEM_INVALID) ? MEM_WORD : req_size;
    assign eff_lane = align_lane(eff_size, req_addr[1:0]);
`endif

    memory_lane_align #(
        .SIZE (SIZE)
    ) u_lane_align (
        .size       (eff_size),
        .lane       (eff_lane),
        .word       (mem[req_idx]),
        .store_data (req_wdata),
        .load_data  (load_data),
        .merged     (merged)
    );

    assign fire   = ((state == ST_IDLE) && memory_enable && (LATENCY == 1)) ||
                    ((state == ST_BUSY) && (count == CNT_W'(1)));
    assign commit = (state == ST_BUSY) && (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            memory_ready   <= 1'b0;
            memory_error   <= 1'b0;
            memory_data_in <= '0;
            op_q           <= MEM_LOAD;
            size_q         <= MEM_BYTE;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            memory_ready <= 1'b0;
            memory_error <= 1'b0;
            if (fire) begin
                memory_ready <= 1'b1;
                if (req_err) begin
                    memory_error   <= 1'b1;
                    memory_data_in <= '0;
                end else if (req_op == MEM_LOAD) begin
                    memory_data_in <= load_data;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (memory_enable) begin
                        op_q    <= mem_op_e'(memory_operation);
                        size_q  <= mem_size_e'(memory_data_size);
                        addr_q  <= memory_address;
                        wdata_q <= memory_data_out;
                        count   <= CNT_W'(LATENCY - 1);
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (count == '0) begin
                        state <= ST_RELEASE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!memory_enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array is not reset; reset only suppresses a pending write.
    always_ff @(posedge clock) begin
        if (!reset && commit && (req_op == MEM_STORE) && !req_err) begin
            mem[req_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Table-driven bench with a scoreboard queue for two memory_responder
// instances (LATENCY 1 and 4) sharing the request fields and clock.
// Expectations follow MEMORY_RESPONDER_ERROR_EN when it is defined.
module tb_memory_responder;

    localparam logic       OP_LD = 1'b0;
    localparam logic       OP_ST = 1'b1;
    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_H  = 2'd1;
    localparam logic [1:0] SZ_W  = 2'd2;
    localparam logic [1:0] SZ_X  = 2'd3;

    logic        clk = 1'b0;
    logic        rst1, rst4, en1, en4;
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        rdy1, rdy4, e1, e4;
    logic [31:0] d1, d4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int unsigned hold;
        string       name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    memory_responder #(.SIZE(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clock(clk), .reset(rst1), .memory_enable(en1), .memory_operation(op),
        .memory_data_size(size), .memory_address(addr), .memory_data_out(wdata),
        .memory_ready(rdy1), .memory_data_in(d1), .memory_error(e1));

    memory_responder #(.SIZE(32), .DEPTH_WORDS(1024), .LATENCY(4)) dut4 (
        .clock(clk), .reset(rst4), .memory_enable(en4), .memory_operation(op),
        .memory_data_size(size), .memory_address(addr), .memory_data_out(wdata),
        .memory_ready(rdy4), .memory_data_in(d4), .memory_error(e4));

    function automatic logic get_rdy(int unsigned which);
        return (which == 4) ? rdy4 : rdy1;
    endfunction
    function automatic logic [31:0] get_data(int unsigned which);
        return (which == 4) ? d4 : d1;
    endfunction
    function automatic logic get_err(int unsigned which);
        return (which == 4) ? e4 : e1;
    endfunction

    task automatic set_en(int unsigned which, logic v);
        if (which == 4) en4 = v;
        else            en1 = v;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(logic o, logic [1:0] s, logic [31:0] a, logic [31:0] w,
                                logic [31:0] ed, logic ee, int unsigned h, string n);
        vec_t v;
        v.op = o; v.size = s; v.addr = a; v.wdata = w;
        v.exp_data = ed; v.exp_err = ee; v.hold = h; v.name = n;
        vecs.push_back(v);
    endfunction

    // One complete request: drive, push expectation, wait (bounded) for the
    // ready pulse, pop and compare, then check the pulse is single and the
    // data holds while enable stays high for 'hold' cycles.
    task automatic do_req(int unsigned which, logic o, logic [1:0] s, logic [31:0] a,
                          logic [31:0] w, logic [31:0] ed, logic ee,
                          int unsigned hold, string name);
        int unsigned cyc;
        int unsigned lat;
        exp_t        e;
        logic [31:0] held;
        lat = (which == 4) ? 4 : 1;
        @(posedge clk); #1;
        op = o; size = s; addr = a; wdata = w;
        set_en(which, 1'b1);
        e.data = ed; e.err = ee;
        sb.push_back(e);
        @(posedge clk); #1;
        // Request fields must be ignored after acceptance.
        op = ~o; size = ~s; addr = $urandom; wdata = $urandom;
        cyc = 1;
        while (!get_rdy(which) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!get_rdy(which)) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: actual=no_ready required=ready", name);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({name, ".latency"}, 32'(cyc), 32'(lat));
            chk({name, ".data"}, get_data(which), e.data);
            chk({name, ".error"}, 32'(get_err(which)), 32'(e.err));
        end
        held = get_data(which);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, ".hold_ready"}, 32'(get_rdy(which)), 32'd0);
            chk({name, ".hold_data"}, get_data(which), held);
        end
        set_en(which, 1'b0);
        @(posedge clk); #1;
        chk({name, ".pulse_end"}, 32'(get_rdy(which)), 32'd0);
        chk({name, ".post_data"}, get_data(which), held);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst1 = 1'b1; rst4 = 1'b1; en1 = 1'b0; en4 = 1'b0;
        op = OP_LD; size = SZ_W; addr = '0; wdata = '0;

        add(OP_ST, SZ_W, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 0,  "st_w_10");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 5,  "ld_w_10");
        add(OP_ST, SZ_B, 32'h13,   32'h123456A5, 32'hDEADBEEF, 1'b0, 0,  "st_b_13");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0, 0,  "ld_w_10b");
        add(OP_LD, SZ_H, 32'h12,   32'h0,        32'h0000A5AD, 1'b0, 0,  "ld_h_12");
        add(OP_LD, SZ_B, 32'h11,   32'h0,        32'h000000BE, 1'b0, 0,  "ld_b_11");
        add(OP_LD, SZ_W, 32'h1010, 32'h0,        32'hA5ADBEEF, 1'b0, 0,  "ld_w_wrap");
        add(OP_ST, SZ_W, 32'h14,   32'h01234567, 32'hA5ADBEEF, 1'b0, 0,  "st_w_14");
        add(OP_ST, SZ_H, 32'h16,   32'h9999CAFE, 32'hA5ADBEEF, 1'b0, 0,  "st_h_16");
        add(OP_LD, SZ_W, 32'h14,   32'h0,        32'hCAFE4567, 1'b0, 0,  "ld_w_14");
        add(OP_LD, SZ_B, 32'h17,   32'h0,        32'h000000CA, 1'b0, 0,  "ld_b_17");
        add(OP_ST, SZ_B, 32'h1014, 32'hFFFFFF77, 32'h000000CA, 1'b0, 0,  "st_b_wrap");
        add(OP_LD, SZ_W, 32'h14,   32'h0,        32'hCAFE4577, 1'b0, 0,  "ld_w_14b");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0, 10, "ld_enable_held");
        add(OP_LD, SZ_B, 32'h12,   32'h0,        32'h000000AD, 1'b0, 0,  "ld_after_drop");
`ifdef MEMORY_RESPONDER_ERROR_EN
        add(OP_LD, SZ_H, 32'h11,   32'h0,        32'h0,        1'b1, 0,  "ld_h_odd");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0, 0,  "ld_w_chk1");
        add(OP_ST, SZ_W, 32'h12,   32'h55555555, 32'h0,        1'b1, 0,  "st_w_mis");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0, 0,  "ld_w_chk2");
        add(OP_LD, SZ_X, 32'h14,   32'h0,        32'h0,        1'b1, 0,  "ld_size3");
`else
        add(OP_LD, SZ_H, 32'h11,   32'h0,        32'h0000BEEF, 1'b0, 0,  "ld_h_odd");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0, 0,  "ld_w_chk1");
        add(OP_ST, SZ_W, 32'h12,   32'h55555555, 32'hA5ADBEEF, 1'b0, 0,  "st_w_mis");
        add(OP_LD, SZ_W, 32'h10,   32'h0,        32'h55555555, 1'b0, 0,  "ld_w_chk2");
        add(OP_LD, SZ_X, 32'h14,   32'h0,        32'hCAFE4577, 1'b0, 0,  "ld_size3");
`endif

        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0; rst4 = 1'b0;
        chk("reset.ready1", 32'(rdy1), 32'd0);
        chk("reset.error1", 32'(e1), 32'd0);
        chk("reset.data1", d1, 32'h0);
        chk("reset.ready4", 32'(rdy4), 32'd0);
        chk("reset.error4", 32'(e4), 32'd0);
        chk("reset.data4", d4, 32'h0);

        foreach (vecs[i]) begin
            do_req(1, vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].hold, vecs[i].name);
        end

        // LATENCY=4: a store aborted by reset in its 2nd BUSY cycle must not
        // write or pulse ready.
        do_req(4, OP_ST, SZ_W, 32'h20, 32'hAAAAAAAA, 32'h0,        1'b0, 0, "l4_st");
        do_req(4, OP_LD, SZ_W, 32'h20, 32'h0,        32'hAAAAAAAA, 1'b0, 0, "l4_ld");
        @(posedge clk); #1;
        op = OP_ST; size = SZ_W; addr = 32'h20; wdata = 32'h11111111; en4 = 1'b1;
        seen = 1'b0;
        @(posedge clk); #1;
        seen |= rdy4;
        @(posedge clk); #1;
        seen |= rdy4;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0; en4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen |= rdy4;
            @(posedge clk); #1;
        end
        chk("l4_abort.no_ready", 32'(seen), 32'd0);
        chk("l4_abort.data_reset", d4, 32'h0);
        do_req(4, OP_LD, SZ_W, 32'h20, 32'h0, 32'hAAAAAAAA, 1'b0, 0, "l4_ld_after_abort");
        do_req(4, OP_LD, SZ_H, 32'h1022, 32'h0, 32'h0000AAAA, 1'b0, 0, "l4_ld_wrap");

        chk("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Word-addressed data memory that acts as the responder on the load/store memory port driven by the reservation-station memory units. It accepts one request at a time and services byte, halfword and word loads and stores against an internal little-endian word array, after a configurable latency. It returns a single-cycle `memory_ready` pulse and holds load data stable until it accepts the next request.

## Interface
- `SIZE`, 32, data and address width
- `DEPTH_WORDS`, 1024, number of words in the array (power of two)
- `LATENCY`, 1, cycles from request acceptance to `memory_ready` (≥1)

- `clock`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `memory_enable`  in  1  request valid (level)
- `memory_operation`  in  1  0 = load, 1 = store
- `memory_data_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = invalid
- `memory_address`  in  SIZE  byte address
- `memory_data_out`  in  SIZE  store data, right-justified (low bits used)
- `memory_ready`  out  1  one-cycle completion pulse
- `memory_data_in`  out  SIZE  load data, right-justified, zero-extended
- `memory_error`  out  1  one-cycle pulse coincident with `memory_ready` on a rejected request

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: `memory_enable`=1 → latch operation, size, address and store data; load counter with LATENCY−1; go to BUSY.
- BUSY: counter decrements each cycle. At 0: assert `memory_ready`, commit the access, go to RELEASE.
- RELEASE: stay while `memory_enable`=1; when `memory_enable`=0 → IDLE. The initiator drops enable for ≥1 cycle between requests. Enable held high after completion never causes a second access.
- Word index = `address[log2(DEPTH_WORDS)+1 : 2]`; upper address bits are ignored (wrap-around).
- Lane = `address[1:0]`, little-endian.
- Load: extract byte or half at the lane into the low bits and zero-fill the rest. The initiator performs sign extension.
- Store: byte/half write merges only the addressed lanes into the word (read-modify-write inside the block); other bytes are unchanged.
- `memory_data_in` is registered. It updates in the ready cycle, for loads only, and holds until the next acceptance. It keeps its last value after a store.
- Array contents are not reset.

## Timing
- Request accepted at the end of cycle N (IDLE, enable=1). `memory_ready`=1 in cycle N+LATENCY only.
- Store writes the array at the edge ending cycle N+LATENCY. A load accepted after that edge observes the new data.
- Minimum request period: LATENCY+2 cycles (ready cycle, one enable-low cycle, accept).
- Request inputs are sampled only at acceptance; changes during BUSY are ignored.
- Reset values: `memory_ready`=0, `memory_error`=0, `memory_data_in`=0, state IDLE, counter 0.
- Reset during BUSY or RELEASE: the pending access is discarded (no write), no ready pulse, and the block returns to IDLE next cycle.
- Reset has priority over a simultaneous acceptance.

## Configuration
- `MEMORY_RESPONDER_ERROR_EN` defined:
  - A half at an odd address, a word with `address[1:0]`≠0, or size 3 is rejected.
  - Rejected requests still pulse `memory_ready` with `memory_error`=1, perform no write, and set `memory_data_in`=0.
- Undefined:
  - Misaligned addresses are aligned down (half: clear bit 0; word: clear bits 1:0), and size 3 is treated as word.
  - `memory_error` is tied 0.

## Structure
- Shared package: size encodings (BYTE=0, HALF=1, WORD=2), operation encodings (LOAD=0, STORE=1), state enum.
- Sub-module `memory_lane_align`: combinational lane extract (load) and lane merge with byte mask (store) from size, `address[1:0]` and data. The top level holds the FSM, counter and array.

## Test plan
- LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 → ready exactly 1 cycle after each acceptance; `memory_data_in`=0xDEADBEEF, held 5 cycles after ready.
- Store byte @0x13 with `memory_data_out`=0x123456A5, then load word @0x10 → 0xA5ADBEEF. Load half @0x12 → 0x0000A5AD. Load byte @0x11 → 0x000000BE.
- Keep enable high for 10 cycles after ready → no further ready. Drop for 1 cycle, issue a load → exactly one new ready.
- Half load @0x11:
  - With macro: ready+error pulse together, data 0, word @0x10 unchanged.
  - Without macro: data 0x0000BEEF, error 0.
- LATENCY=4, store word 0x11111111 @0x20, reset in the 2nd BUSY cycle → no ready; a later load @0x20 returns the prior contents.
- Load @ byte address (DEPTH_WORDS·4)+0x10 → same word as @0x10 (wrap).
